sort_engine: RTL and testbench

//   Parametrised in-place bubble sort engine with early exit, run over a single-port data memory.

---
 rtl/sort_engine.sv | 168 ++++++++++++++++
 tb/tb_sort_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// In-place bubble sort engine with early exit over a single-port memory.
// Supports runtime length, ascending/descending order, signed/unsigned
// compare, a saturating cycle counter and a host pass-through port that owns
// the memory whenever the engine is idle.
module sort_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CYC_W  = 16,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic [ADDR_W:0]   len,
    input  logic              desc,
    input  logic              sgn,
    output logic              busy,
    output logic              done,
    output logic [CYC_W-1:0]  cycles,
    input  logic [ADDR_W-1:0] hst_addr,
    input  logic [DATA_W-1:0] hst_wdata,
    input  logic              hst_we,
    output logic [DATA_W-1:0] hst_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;

    state_t              state, state_nxt;
    logic                run_q;
    logic                armed;
    logic                desc_q, sgn_q, swp;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W:0]     lim;
    logic [DATA_W-1:0]   a, b;

    logic                start;
    logic                pass_more;
    logic                last_pass;
    logic                a_lt_b, a_gt_b, out_of_order;
    logic [ADDR_W:0]     i_inc;
    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic [ADDR_W-1:0]   eng_addr;
    logic [DATA_W-1:0]   eng_wdata;
    logic                eng_we;

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign addr_a    = ADDR_W'(BASE) + i;
    assign addr_b    = addr_a + ADDR_W'(1);
    assign i_inc     = {1'b0, i} + (ADDR_W+1)'(1);
    assign pass_more = i_inc < lim;
    assign last_pass = lim == (ADDR_W+1)'(1);

    assign a_lt_b       = sgn_q ? ($signed(a) < $signed(b)) : (a < b);
    assign a_gt_b       = sgn_q ? ($signed(a) > $signed(b)) : (a > b);
    // Strict comparison: equal elements never swap, keeping the sort stable.
    assign out_of_order = desc_q ? a_lt_b : a_gt_b;

    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);
    assign start = run && !run_q && !busy;

    // Memory port: host owns it when idle; host writes are blocked while busy
    // and until the first clock after reset release.
    assign mem_addr  = busy ? eng_addr  : hst_addr;
    assign mem_wdata = busy ? eng_wdata : hst_wdata;
    assign mem_we    = busy ? eng_we    : (hst_we && armed);
    assign hst_rdata = mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and engine memory-port drive.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned (no latch inferred).
        state_nxt = state;
        eng_addr  = addr_a;
        eng_wdata = b;
        eng_we    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (len < (ADDR_W+1)'(2)) ? DONE : RD_A;
            end
            RD_A: state_nxt = RD_B;
            RD_B: begin
                eng_addr  = addr_b;
                state_nxt = CMP;
            end
            CMP:  state_nxt = out_of_order ? WR_A : NEXT;
            WR_A: begin
                eng_wdata = b;
                eng_we    = 1'b1;
                state_nxt = WR_B;
            end
            WR_B: begin
                eng_addr  = addr_b;
                eng_wdata = a;
                eng_we    = 1'b1;
                state_nxt = NEXT;
            end
            NEXT: begin
                if (pass_more)               state_nxt = RD_A;
                else if (!swp || last_pass)  state_nxt = DONE;
                else                         state_nxt = RD_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: run edge detector, latched modes, indices, operands, counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: run_q resets high so a run held high through reset is not
            // mistaken for a rising edge once reset is released.
            run_q  <= 1'b1;
            armed  <= 1'b0;
            desc_q <= 1'b0;
            sgn_q  <= 1'b0;
            swp    <= 1'b0;
            i      <= '0;
            lim    <= '0;
            a      <= '0;
            b      <= '0;
            cycles <= '0;
        end else begin
            run_q <= run;
            armed <= 1'b1;
            if (start) begin
                desc_q <= desc;
                sgn_q  <= sgn;
                i      <= '0;
                lim    <= len - (ADDR_W+1)'(1);
                swp    <= 1'b0;
                cycles <= '0;
            end else begin
                if (busy && (cycles != {CYC_W{1'b1}}))
                    cycles <= cycles + CYC_W'(1);
                case (state)
                    RD_A: a   <= mem_rdata;
                    RD_B: b   <= mem_rdata;
                    WR_B: swp <= 1'b1;
                    NEXT: begin
                        if (pass_more) begin
                            i <= i + ADDR_W'(1);
                        end else if (swp && !last_pass) begin
                            lim <= lim - (ADDR_W+1)'(1);
                            i   <= '0;
                            swp <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Directed testbench for sort_engine: a behavioural single-port memory with
// combinational read, loaded and dumped through the host pass-through port.
module tb_sort_engine;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 5;   // small counter so saturation is reachable
    localparam int B  = 2;   // non-zero element base

    logic          clk, rstn, run, desc, sgn;
    logic [AW:0]   len;
    logic          busy, done;
    logic [CW-1:0] cycles;
    logic [AW-1:0] hst_addr, mem_addr;
    logic [DW-1:0] hst_wdata, hst_rdata, mem_wdata, mem_rdata;
    logic          hst_we, mem_we;

    logic [DW-1:0] mem [0:255];
    int            checks = 0;
    int            errors = 0;
    int            we_busy = 0;
    int            we_snap;

    sort_engine #(.DATA_W(DW), .ADDR_W(AW), .CYC_W(CW), .BASE(B)) dut (
        .clk(clk), .rstn(rstn), .run(run), .len(len), .desc(desc), .sgn(sgn),
        .busy(busy), .done(done), .cycles(cycles),
        .hst_addr(hst_addr), .hst_wdata(hst_wdata), .hst_we(hst_we),
        .hst_rdata(hst_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, synchronous write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Count engine-side writes while busy.
    always @(posedge clk) if (busy && mem_we) we_busy <= we_busy + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [31:0] d);
        hst_addr = AW'(addr); hst_wdata = d; hst_we = 1'b1;
        @(posedge clk); #1;
        hst_we = 1'b0;
    endtask

    task automatic expect_mem(input string tag, input int addr, input logic [31:0] exp);
        hst_addr = AW'(addr);
        #1;
        check(tag, hst_rdata, exp);
    endtask

    // Start a sort and wait (bounded) for done; optionally poke host writes while busy.
    task automatic run_sort(input logic [AW:0] l, input logic d, input logic s,
                            input bit poke, input string tag);
        int n;
        run = 1'b0;
        @(posedge clk); #1;
        len = l; desc = d; sgn = s; run = 1'b1;
        @(posedge clk); #1;
        if (poke) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            hst_addr = AW'(200); hst_wdata = 32'h0000_0BAD; hst_we = 1'b1;
            repeat (10) begin @(posedge clk); #1; end
            hst_we = 1'b0;
        end
        n = 0;
        while (!done && n < 2000) begin @(posedge clk); #1; n++; end
        check({tag, "_done"}, 32'(done), 32'd1);
        run = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; run = 1'b0; len = '0; desc = 1'b0; sgn = 1'b0;
        hst_addr = '0; hst_wdata = '0; hst_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        host_write(200, 32'h0000_1234);

        // T1: [5,1,4,2] ascending unsigned; 32 busy clocks saturate at 31.
        host_write(B+0, 5); host_write(B+1, 1); host_write(B+2, 4); host_write(B+3, 2);
        run_sort(9'd4, 1'b0, 1'b0, 1'b1, "t1");
        check("t1_cycles_sat", 32'(cycles), 32'd31);
        check("t1_busy", 32'(busy), 32'd0);
        expect_mem("t1_m0", B+0, 1);
        expect_mem("t1_m1", B+1, 2);
        expect_mem("t1_m2", B+2, 4);
        expect_mem("t1_m3", B+3, 5);
        expect_mem("t1_host_iso", 200, 32'h0000_1234);

        // T2: already sorted; one pass, no engine writes.
        host_write(B+0, 1); host_write(B+1, 2); host_write(B+2, 3); host_write(B+3, 4);
        we_snap = we_busy;
        run_sort(9'd4, 1'b0, 1'b0, 1'b0, "t2");
        check("t2_cycles", 32'(cycles), 32'd12);
        check("t2_no_writes", 32'(we_busy - we_snap), 32'd0);
        expect_mem("t2_m0", B+0, 1);
        expect_mem("t2_m3", B+3, 4);

        // T3: [-1,3,-7] descending signed -> [3,-1,-7].
        host_write(B+0, 32'hFFFF_FFFF); host_write(B+1, 3); host_write(B+2, 32'hFFFF_FFF9);
        run_sort(9'd3, 1'b1, 1'b1, 1'b0, "t3");
        check("t3_cycles", 32'(cycles), 32'd14);
        expect_mem("t3_m0", B+0, 3);
        expect_mem("t3_m1", B+1, 32'hFFFF_FFFF);
        expect_mem("t3_m2", B+2, 32'hFFFF_FFF9);

        // T4: same data ascending unsigned -> [3,0xFFFFFFF9,0xFFFFFFFF].
        host_write(B+0, 32'hFFFF_FFFF); host_write(B+1, 3); host_write(B+2, 32'hFFFF_FFF9);
        run_sort(9'd3, 1'b0, 1'b0, 1'b0, "t4");
        check("t4_cycles", 32'(cycles), 32'd16);
        expect_mem("t4_m0", B+0, 3);
        expect_mem("t4_m1", B+1, 32'hFFFF_FFF9);
        expect_mem("t4_m2", B+2, 32'hFFFF_FFFF);

        // T5: len=1 and len=0 finish at once with memory untouched.
        host_write(B+0, 9); host_write(B+1, 8);
        run_sort(9'd1, 1'b0, 1'b0, 1'b0, "t5a");
        check("t5a_cycles", 32'(cycles), 32'd0);
        expect_mem("t5a_m0", B+0, 9);
        expect_mem("t5a_m1", B+1, 8);
        run_sort(9'd0, 1'b0, 1'b0, 1'b0, "t5b");
        check("t5b_cycles", 32'(cycles), 32'd0);
        check("t5b_busy", 32'(busy), 32'd0);
        expect_mem("t5b_m0", B+0, 9);

        // T6: reset mid-sort with run held high; host isolated during reset.
        host_write(B+0, 5); host_write(B+1, 1); host_write(B+2, 4); host_write(B+3, 2);
        run = 1'b0;
        @(posedge clk); #1;
        len = 9'd4; desc = 1'b0; sgn = 1'b0; run = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        check("t6_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        hst_addr = AW'(200); hst_wdata = 32'h0000_0BAD; hst_we = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_cycles", 32'(cycles), 32'd0);
        check("t6_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        hst_we = 1'b0;
        #2 rstn = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t6_no_start_held", 32'(busy), 32'd0);
        expect_mem("t6_host_iso", 200, 32'h0000_1234);
        run = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        check("t6_restart_busy", 32'(busy), 32'd1);
        begin
            int n;
            n = 0;
            while (!done && n < 2000) begin @(posedge clk); #1; n++; end
        end
        check("t6_done", 32'(done), 32'd1);
        run = 1'b0;
        expect_mem("t6_m0", B+0, 1);
        expect_mem("t6_m1", B+1, 2);
        expect_mem("t6_m2", B+2, 4);
        expect_mem("t6_m3", B+3, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
